hw_accel_stream_out_buffer: RTL and testbench
=============================================

// Module: hw_accel_stream_out_buffer
// PURPOSE
//   Downstream stage of the hw_accel pixel pipeline. Takes packed 32-bit words
//   from the RGB/gray packer, which issues them with valid only (no stall).
//   Buffers them in a FIFO and presents them as a valid/ready stream to the
//   DMA write channel. Asserts a last flag on the final word of each frame.
//   Flags, and never silently hides, input words dropped on overflow.
// PARAMETERS
//   DATA_WIDTH   32     width of packed word
//   FRAME_WORDS  27648  words per frame (192*192*3/4); must be >= 2
//   FIFO_AW      9      FIFO address width; depth = 2**FIFO_AW = 512
// PORTS
//   clk            input   1           pipeline clock
//   rst            input   1           asynchronous active-low reset (0 = reset)
//   frame_start    input   1           1-cycle pulse; flush and restart framing
//   in_data        input   DATA_WIDTH  packed word from packer
//   in_valid       input   1           in_data valid; no backpressure upstream
//   out_data       output  DATA_WIDTH  word to DMA
//   out_valid      output  1           out_data valid
//   out_ready      input   1           DMA accepts word when out_valid & out_ready
//   out_last       output  1           current out_data is last word of frame
//   fifo_level     output  FIFO_AW+1   words currently stored (0..2**FIFO_AW)
//   overflow       output  1           sticky: an input word was dropped
//   overflow_clr   input   1           synchronous clear of overflow
// BEHAVIOUR
//   Reset (rst=0, async): FIFO empty, wr/rd pointers 0, out_valid=0,
//     out_last=0, out_data=0, fifo_level=0, overflow=0, word counter=0.
//   Storage: dual-port RAM, FIFO_AW+1-bit pointers (MSB = wrap bit).
//     full = (ptr LSBs equal, MSBs differ). empty = (pointers equal).
//   Read side: first-word-fall-through. A word written in cycle N
//     appears on out_data with out_valid=1 in cycle N+1 (latency 1).
//     out_data/out_valid/out_last hold stable while out_valid & !out_ready.
//   Write accept = in_valid & (!full | (out_valid & out_ready)).
//     A word arriving at full is accepted if a read completes in the same
//     cycle. Otherwise it is dropped and overflow is set next cycle.
//   overflow: set on drop; cleared by overflow_clr. Set wins if both occur
//     in the same cycle.
//   fifo_level: +1 on write-only, -1 on read-only, unchanged on both.
//     Registered, so it is valid the cycle after the event.
//   Frame counter: counts completed output handshakes, 0..FRAME_WORDS-1.
//     out_last = out_valid & (count == FRAME_WORDS-1).
//     On the handshake with out_last, count wraps to 0.
//   frame_start (synchronous, highest priority):
//     - empties FIFO: pointers equal, level 0, out_valid=0 next cycle
//     - resets frame counter to 0
//     - a word with in_valid in the same cycle is written as word 0 of the
//       new frame; out_valid=1 next cycle, level=1
//     - does not touch overflow
//   A handshake in the frame_start cycle is discarded; it does not count.
//   Words are in-order: no reordering, duplication, or loss except counted
//   drops.
//   No combinational path from in_* to out_*; out_ready affects only the
//   next-state logic.
// TESTING
//   1 Stream: 27648 consecutive in_valid words 0..27647, out_ready=1.
//     -> out_data identical sequence, 1 cycle late.
//     -> out_last high only with data 27647; overflow=0; level ends at 0.
//   2 Stall: out_ready=0, 600 in_valid words 0..599.
//     -> level saturates at 512; overflow=1 from the cycle after word 512.
//     -> After out_ready=1, exactly words 0..511 emerge in order.
//   3 Full + read: FIFO full, then in_valid=1 and out_ready=1 every cycle
//     for 100 cycles.
//     -> level stays 512, overflow stays 0, no word lost.
//   4 Resync: frame_start at output word 1000 with in_valid=1, data 0xA5A5A5A5.
//     -> next cycle: level=1, out_data=0xA5A5A5A5.
//     -> out_last after 27647 further handshakes.
//   5 Reset: rst=0 mid-frame with level=37.
//     -> all outputs 0 immediately (async).
//     -> after release, first input word appears 1 cycle later with count=0.
//   6 Clear: overflow_clr pulsed on the same cycle as a drop -> overflow stays 1.
//     Pulsed with no drop -> overflow=0.

Source files
------------

// File: rtl/hw_accel_stream_out_buffer.sv
// Output buffer for the hw_accel pixel pipeline: a first-word-fall-through FIFO
// that turns the packer's valid-only word stream into a valid/ready stream with a frame-last flag.
module hw_accel_stream_out_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_WORDS = 27648,
  parameter int FIFO_AW     = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(FRAME_WORDS);
  localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_WORDS - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic [CW-1:0]         count, count_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  valid_nxt, last_nxt;
  logic                  full, handshake, rd_en, wr_en, drop;
  logic [FIFO_AW-1:0]    wr_addr;

  assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign handshake = out_valid & out_ready;
  assign rd_en     = handshake & ~frame_start;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign wr_en     = in_valid & (frame_start | ~full | handshake);
  assign drop      = in_valid & ~wr_en;
  assign wr_addr   = frame_start ? '0 : wr_ptr[FIFO_AW-1:0];

  // The head word always lives in out_data; mem[rd_ptr] holds the same value.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = fifo_level;
    data_nxt   = out_data;
    count_nxt  = count;
    if (frame_start) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = {{FIFO_AW{1'b0}}, in_valid};
      level_nxt  = {{FIFO_AW{1'b0}}, in_valid};
      count_nxt  = '0;
      if (in_valid) data_nxt = in_data;
    end else begin
      if (wr_en) wr_ptr_nxt = wr_ptr + 1'b1;
      if (rd_en) rd_ptr_nxt = rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_nxt = fifo_level + 1'b1;
        2'b01:   level_nxt = fifo_level - 1'b1;
        default: level_nxt = fifo_level;
      endcase
      if (rd_en) begin
        // Next head is the word being written now when only one word was stored.
        data_nxt  = (rd_ptr_nxt == wr_ptr) ? in_data : mem[rd_ptr_nxt[FIFO_AW-1:0]];
        count_nxt = (count == LAST_COUNT) ? '0 : count + 1'b1;
      end else if (!out_valid && wr_en) begin
        data_nxt = in_data;
      end
    end
    valid_nxt = (level_nxt != '0);
    last_nxt  = valid_nxt && (count_nxt == LAST_COUNT);
  end

  // NOTE: storage array has no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      count      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      fifo_level <= level_nxt;
      count      <= count_nxt;
      out_data   <= data_nxt;
      out_valid  <= valid_nxt;
      out_last   <= last_nxt;
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hw_accel_stream_out_buffer.sv
// Directed bench for hw_accel_stream_out_buffer: streaming, stall/overflow,
// full-with-read, frame resync, async reset and overflow clear.
module tb_hw_accel_stream_out_buffer;

  localparam int DW    = 32;
  localparam int FW    = 27648;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [AW:0]   fifo_level;
  logic          overflow;
  logic          overflow_clr;

  int errors = 0;
  int checks = 0;

  hw_accel_stream_out_buffer #(.DATA_WIDTH(DW), .FRAME_WORDS(FW), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_data(in_data),
    .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .fifo_level(fifo_level),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_start  = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #2;
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_last", out_last, 0);
    check("reset_level", fifo_level, 0);
    check("reset_ovf", overflow, 0);
    do_reset();

    // Test 1: full-frame stream with out_ready held high.
    for (int i = 0; i < FW; i++) begin
      in_valid = 1'b1; in_data = DW'(i); out_ready = 1'b1;
      step();
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, i);
      check("t1_last", out_last, (i == FW - 1));
      if (i == 100) check("t1_level", fifo_level, 1);
    end
    in_valid = 1'b0;
    step();
    check("t1_end_valid", out_valid, 0);
    check("t1_end_level", fifo_level, 0);
    check("t1_end_ovf", overflow, 0);

    // Test 2 + 6: stall, saturate, drop; clear coinciding with a drop.
    out_ready = 1'b0;
    for (int j = 0; j < 600; j++) begin
      in_valid = 1'b1; in_data = DW'(j);
      overflow_clr = (j == 550);
      step();
      check("t2_level", fifo_level, (j < DEPTH) ? j + 1 : DEPTH);
      check("t2_ovf", overflow, (j >= DEPTH));
      check("t2_head", out_data, 0);
    end
    idle_inputs();
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check("t2_drain_valid", out_valid, 1);
      check("t2_drain_data", out_data, k);
      step();
    end
    check("t2_empty_valid", out_valid, 0);
    check("t2_empty_level", fifo_level, 0);
    check("t2_ovf_kept", overflow, 1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("t6_clr", overflow, 0);

    // Test 3: full FIFO with simultaneous read and write every cycle.
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 1'b1; in_data = DW'(1000 + k);
      step();
    end
    check("t3_full_level", fifo_level, DEPTH);
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'b1; in_data = DW'(2000 + c); out_ready = 1'b1;
      check("t3_rw_data", out_data, 1000 + c);
      step();
      check("t3_rw_level", fifo_level, DEPTH);
      check("t3_rw_ovf", overflow, 0);
    end
    in_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      check("t3_drain_data", out_data, (k < 412) ? 1100 + k : 2000 + (k - 412));
      step();
    end
    check("t3_empty_valid", out_valid, 0);

    // Test 4: resync with frame_start while output word 1000 is presented.
    do_reset();
    for (int i = 0; i <= 1000; i++) begin
      in_valid = 1'b1; in_data = DW'(i); out_ready = 1'b1;
      step();
    end
    check("t4_pre_data", out_data, 1000);
    frame_start = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_A5A5;
    step();
    frame_start = 1'b0;
    check("t4_level", fifo_level, 1);
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, 32'hA5A5_A5A5);
    check("t4_last0", out_last, 0);
    for (int i = 1; i < FW; i++) begin
      in_valid = 1'b1; in_data = DW'(i); out_ready = 1'b1;
      step();
      check("t4_data_seq", out_data, i);
      check("t4_last", out_last, (i == FW - 1));
    end
    in_valid = 1'b0;
    step();
    check("t4_end_level", fifo_level, 0);

    // Test 5: asynchronous reset mid-frame with 37 words stored.
    out_ready = 1'b0;
    for (int k = 0; k < 37; k++) begin
      in_valid = 1'b1; in_data = DW'(500 + k);
      step();
    end
    in_valid = 1'b0;
    check("t5_level", fifo_level, 37);
    #2 rst = 1'b0;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_data", out_data, 0);
    check("t5_async_level", fifo_level, 0);
    check("t5_async_last", out_last, 0);
    check("t5_async_ovf", overflow, 0);
    step();
    rst = 1'b1;
    step();
    in_valid = 1'b1; in_data = 32'h1234_5678;
    step();
    in_valid = 1'b0;
    check("t5_first_valid", out_valid, 1);
    check("t5_first_data", out_data, 32'h1234_5678);
    check("t5_first_last", out_last, 0);
    check("t5_first_level", fifo_level, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
